// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states, counter width.
// No logic; constants and types only.
// Not applicable.
package lsu_pkg;

    // Access size/signedness encodings carried on funct3
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Width of the bus-wait timeout counter (TIMEOUT is at most 255)
    localparam int TMO_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } lsu_state_t;

endpackage

// File: rtl/lsu_lane.sv
// Lane steering: byte enables, store-data replication, legality/alignment checks, load extract+extend.
// Purely combinational, zero latency.
// No backpressure; outputs follow inputs.
import lsu_pkg::*;

module lsu_lane (
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic        is_store,
    input  logic [31:0] write_data,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_offset,
    input  logic [31:0] ld_rdata,
    output logic [3:0]  byte_en,
    output logic [31:0] lane_wdata,
    output logic        illegal,
    output logic        misaligned,
    output logic [31:0] ld_result
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Request decode: legality, alignment, byte enables and replicated store data
    always_comb begin
        illegal    = 1'b1;
        misaligned = 1'b0;
        byte_en    = 4'b0000;
        lane_wdata = 32'd0;
        case (funct3)
            F3_B, F3_H, F3_W: illegal = 1'b0;
            F3_BU, F3_HU:     illegal = is_store;   // no unsigned stores
            default:          illegal = 1'b1;
        endcase
        case (funct3[1:0])
            2'b00: begin
                byte_en    = 4'b0001 << offset;
                lane_wdata = {4{write_data[7:0]}};
            end
            2'b01: begin
                misaligned = offset[0];
                byte_en    = offset[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{write_data[15:0]}};
            end
            2'b10: begin
                misaligned = (offset != 2'b00);
                byte_en    = 4'b1111;
                lane_wdata = write_data;
            end
            default: ;
        endcase
        // Loads keep the write-data bus quiet
        if (!is_store) begin
            lane_wdata = 32'd0;
        end
    end

    // Pick the addressed byte/halfword lane out of the returned word
    always_comb begin
        ld_byte = ld_rdata[7:0];
        case (ld_offset)
            2'd0: ld_byte = ld_rdata[7:0];
            2'd1: ld_byte = ld_rdata[15:8];
            2'd2: ld_byte = ld_rdata[23:16];
            2'd3: ld_byte = ld_rdata[31:24];
            default: ;
        endcase
        ld_half = ld_offset[1] ? ld_rdata[31:16] : ld_rdata[15:0];
    end

    // Sign/zero extension according to the captured load type
    always_comb begin
        ld_result = ld_rdata;
        case (ld_funct3)
            F3_B:    ld_result = {{24{ld_byte[7]}}, ld_byte};
            F3_BU:   ld_result = {24'd0, ld_byte};
            F3_H:    ld_result = {{16{ld_half[15]}}, ld_half};
            F3_HU:   ld_result = {16'd0, ld_half};
            default: ld_result = ld_rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit bridging the core execute stage to a req/ack memory bus.
// Latency: 2 stall cycles for a zero-wait bus access, +1 per bus wait cycle; faults take 0.
// Backpressure: stall held while an access is pending; bus waits bounded by TIMEOUT cycles.
import lsu_pkg::*;

module load_store_unit #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  funct3,
    input  logic [31:0] address,
    input  logic [31:0] writeData,
    output logic [31:0] readData,
    output logic        stall,
    output logic        fault,
    output logic        busError,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    lsu_state_t       state;
    logic [TMO_W-1:0] wait_cnt;
    logic [2:0]       ld_f3;
    logic [1:0]       ld_ofs;

    logic        req;
    logic        req_legal;
    logic        illegal;
    logic        misaligned;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic [31:0] ld_result;

    // Load extraction uses the captured funct3/offset so it is independent of the core's inputs
    lsu_lane u_lane (
        .funct3     (funct3),
        .offset     (address[1:0]),
        .is_store   (MemWrite),
        .write_data (writeData),
        .ld_funct3  (ld_f3),
        .ld_offset  (ld_ofs),
        .ld_rdata   (bus_rdata),
        .byte_en    (lane_be),
        .lane_wdata (lane_wdata),
        .illegal    (illegal),
        .misaligned (misaligned),
        .ld_result  (ld_result)
    );

    assign req       = MemRead | MemWrite;
    assign req_legal = req & ~illegal & ~misaligned;

    // Faults are only raised for a fresh request; the core moves on without stalling
    assign fault = (state == IDLE) && req && (illegal || misaligned);
    assign stall = ((state == IDLE) && req_legal) || (state == WAIT);

    // Access FSM with registered bus outputs, load result and timeout counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            ld_f3     <= 3'd0;
            ld_ofs    <= 2'd0;
            readData  <= 32'd0;
            busError  <= 1'b0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= 32'd0;
            bus_be    <= 4'd0;
            bus_wdata <= 32'd0;
        end else begin
            busError <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_legal) begin
                        state     <= WAIT;
                        wait_cnt  <= '0;
                        bus_req   <= 1'b1;
                        bus_we    <= MemWrite;
                        bus_addr  <= {address[31:2], 2'b00};
                        bus_be    <= lane_be;
                        bus_wdata <= lane_wdata;
                        ld_f3     <= funct3;
                        ld_ofs    <= address[1:0];
                    end
                end
                WAIT: begin
                    if (bus_ack) begin
                        // An ack in the final allowed cycle still completes normally
                        state     <= DONE;
                        bus_req   <= 1'b0;
                        bus_we    <= 1'b0;
                        bus_addr  <= 32'd0;
                        bus_be    <= 4'd0;
                        bus_wdata <= 32'd0;
                        if (!bus_we) begin
                            readData <= ld_result;
                        end
                    end else if (wait_cnt == TMO_LAST) begin
                        state     <= DONE;
                        busError  <= 1'b1;
                        readData  <= 32'd0;
                        bus_req   <= 1'b0;
                        bus_we    <= 1'b0;
                        bus_addr  <= 32'd0;
                        bus_be    <= 4'd0;
                        bus_wdata <= 32'd0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                // The core still shows the finished request here; never relaunch it
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle load/store unit between the single-cycle core's execute stage (ALU address, `MemRead`/`MemWrite`, funct3, rs2 data) and a request/acknowledge memory bus with variable latency. It replaces the core's direct combinational data-memory access. It handles byte, halfword and word accesses with lane steering and sign/zero extension, detects misaligned and illegal accesses, bounds bus waits with a timeout, and stalls the core until each access completes.

## Interface
Parameters:
- `TIMEOUT`, default 255: maximum cycles waiting in WAIT for `bus_ack` before aborting; legal range 1–255.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `MemRead` in 1: load request from control unit.
- `MemWrite` in 1: store request; wins if both requests are high.
- `funct3` in 3: access size and signedness.
- `address` in 32: byte address from ALU.
- `writeData` in 32: store data (rs2).
- `readData` out 32: extended load result, registered.
- `stall` out 1: the core must hold PC and all state while this is high.
- `fault` out 1: one-cycle pulse for a misaligned access or illegal funct3.
- `busError` out 1: one-cycle pulse on timeout.
- `bus_req` out 1: bus request, registered.
- `bus_we` out 1: 1 for a store.
- `bus_addr` out 32: word-aligned address, with `address[1:0]` forced to 0.
- `bus_be` out 4: byte enables.
- `bus_wdata` out 32: lane-replicated store data.
- `bus_ack` in 1: completion; may be high in the same cycle `bus_req` rises.
- `bus_rdata` in 32: read data, valid with `bus_ack`.

## Operation
- FSM states:
  - IDLE: no access in flight. On a legal request, capture the bus fields and go to WAIT. On an illegal request, pulse `fault` and stay in IDLE with no bus activity.
  - WAIT: an access is on the bus. On `bus_ack`, go to DONE. On timeout, go to DONE.
  - DONE: always returns to IDLE on the next cycle.
- Legal funct3 values:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other value is illegal and raises `fault`.
- Misaligned accesses raise `fault`:
  - Halfword with `address[0]`=1.
  - Word with `address[1:0]`≠0.
- Byte enables and write data:
  - Byte access: `bus_be` = 1<<`address[1:0]`; `bus_wdata` = the low byte of `writeData` replicated ×4.
  - Halfword access: `bus_be` = 0011 or 1100, selected by `address[1]`; `bus_wdata` = the low halfword of `writeData` replicated ×2.
  - Word access: `bus_be` = 1111.
  - Loads drive `bus_be` the same way, with `bus_we`=0 and `bus_wdata`=0.
- Load result: the selected lane of `bus_rdata` is sign-extended for LB/LH and zero-extended for LBU/LHU. It is written into `readData` on the `bus_ack` edge.
- Stores leave `readData` unchanged.
- Timeout:
  - The counter clears on entry to WAIT and increments each WAIT cycle without `bus_ack`.
  - When it reaches `TIMEOUT`, `busError` pulses for one cycle (the cycle the FSM is in DONE), `readData`=0, and the FSM goes to DONE.
- `bus_ack` in IDLE or DONE is ignored.
- In DONE, the core still presents the same request. It must not be relaunched; DONE always returns to IDLE.

## Timing
- `stall` is combinational:
  - High in IDLE when a legal request is present.
  - High throughout WAIT.
  - Low in DONE and whenever `fault` is set.
- Zero-wait access:
  - Cycle 0: IDLE accepts the request; `stall`=1.
  - Cycle 1: WAIT; `bus_req`=1 and `bus_ack`=1.
  - Cycle 2: DONE; `stall`=0 and `readData` is valid.
  - The core therefore sees 2 stall cycles.
- Each additional bus wait cycle adds one stall cycle.
- `bus_req`, `bus_we`, `bus_addr`, `bus_be` and `bus_wdata` are registered. They are stable from entry to WAIT until the `bus_ack` edge. `bus_req` drops on the edge leaving WAIT.
- `fault` asserts combinationally in the same cycle as the illegal request; the core advances without stalling.
- Reset value of every output is 0, state is IDLE, and the timeout counter is 0. Reset asserted mid-WAIT drops `bus_req` asynchronously. A late `bus_ack` after reset is ignored.

## Structure
- Package `lsu_pkg` holds:
  - funct3 constants (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`).
  - The state enum (IDLE/WAIT/DONE).
  - The `TIMEOUT` width constant (8 bits).
- Sub-module `lsu_lane` is combinational. It produces byte enables, write-data replication, misalignment/illegal detection and load extraction/extension. The FSM, registers and timeout counter stay in `load_store_unit`.

## Test plan
- LB at `address`=0x103, `bus_rdata`=0x80AABBCC, ack on first WAIT cycle -> `bus_addr`=0x100, `bus_be`=1000, `readData`=0xFFFFFF80, `stall` high exactly 2 cycles.
- LHU at 0x202, `bus_rdata`=0x8001_1234 -> `bus_be`=1100, `readData`=0x00008001; LH with the same data -> `readData`=0xFFFF8001.
- SB `writeData`=0x12345678 at 0x301 with ack after 3 wait cycles -> `bus_we`=1, `bus_be`=0010, `bus_wdata`=0x78787878 held stable 4 cycles, `readData` unchanged.
- LW at 0x402, and funct3=011 at 0x400 -> `fault`=1 for one cycle, `stall`=0, `bus_req` never asserted.
- `TIMEOUT`=4, LW with no `bus_ack` -> `busError` pulse in the cycle after the 4th WAIT cycle, `readData`=0, FSM returns to IDLE.
- `rst` low during WAIT -> all outputs 0 immediately; `bus_ack` pulsed 1 cycle after release -> ignored, state stays IDLE.
